image_read_ctrl: RTL and testbench

IMAGE_READ_CTRL -- requirements
Module: image_read_ctrl

---
 rtl/image_read_ctrl.sv | 128 ++++++++++++
 tb/tb_image_read_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_read_ctrl.sv
// Image read controller: fetches NUM_BYTES bytes from a one-cycle-latency memory
// and streams them out through a 2-entry FIFO with a valid/ready handshake.
module image_read_ctrl #(
   parameter int NUM_BYTES = 200,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic              busy,
   output logic              done
);
   localparam int               CNT_W    = $clog2(NUM_BYTES + 1);
   localparam logic [CNT_W-1:0] N_CNT    = CNT_W'(NUM_BYTES);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state;
   logic [CNT_W-1:0]  issued_cnt;
   logic [CNT_W-1:0]  out_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic              inflight;
   logic              busy_q;
   logic              done_q;
   logic [DATA_W-1:0] fifo_mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        fifo_cnt;
   logic              push;
   logic              pop;
   logic              rd_en;
   logic              cancel;
   logic [2:0]        used_n;

   assign push   = inflight;
   assign pop    = out_valid & out_ready;
   assign cancel = abort && (state != IDLE);

   // Credit counts the byte leaving this cycle as freed, which keeps one read per cycle
   // flowing with out_ready held high while never letting the FIFO exceed two entries.
   assign used_n = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
   assign rd_en  = (state == FETCH) && !abort && (issued_cnt < N_CNT) && (used_n < 3'd2);

   assign mem_rd_en = rd_en;
   assign mem_addr  = addr_q;
   assign out_valid = (fifo_cnt != 2'd0);
   assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
   assign out_last  = out_valid && (out_cnt == LAST_IDX);
   assign busy      = busy_q;
   assign done      = done_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         issued_cnt <= '0;
         out_cnt    <= '0;
         addr_q     <= '0;
         inflight   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         fifo_cnt   <= 2'd0;
      end else begin
         done_q   <= 1'b0;
         inflight <= rd_en;
         fifo_cnt <= fifo_cnt + 2'(push) - 2'(pop);
         if (push) wr_ptr <= ~wr_ptr;
         if (pop) begin
            rd_ptr  <= ~rd_ptr;
            out_cnt <= out_cnt + CNT_W'(1);
         end
         if (rd_en) begin
            issued_cnt <= issued_cnt + CNT_W'(1);
            if (issued_cnt != LAST_IDX) addr_q <= addr_q + ADDR_W'(1);
         end
         // Cancel drops buffered bytes and the pending memory return in one edge.
         if (cancel) begin
            state    <= IDLE;
            busy_q   <= 1'b0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            fifo_cnt <= 2'd0;
         end else begin
            case (state)
               IDLE: begin
                  if (start && !abort) begin
                     state      <= FETCH;
                     busy_q     <= 1'b1;
                     issued_cnt <= '0;
                     out_cnt    <= '0;
                     addr_q     <= '0;
                  end
               end
               FETCH: begin
                  if (rd_en && (issued_cnt == LAST_IDX)) state <= DRAIN;
               end
               DRAIN: begin
                  if (pop && out_last) begin
                     state  <= DONE;
                     done_q <= 1'b1;
                  end
               end
               DONE: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= mem_rdata;
   end
endmodule

// File: tb/tb_image_read_ctrl.sv
// Scoreboard bench for image_read_ctrl: three instances (4, 1 and 200 bytes) share
// one clock; stimulus queues expected bytes, a monitor pops and compares on transfers.
module tb_image_read_ctrl;
   localparam int NI = 3;

   function automatic int nb(input int g);
      return (g == 0) ? 4 : ((g == 1) ? 1 : 200);
   endfunction

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic       start [NI];
   logic       abort [NI];
   logic       out_ready [NI];
   logic       mem_rd_en [NI];
   logic       out_valid [NI];
   logic       out_last [NI];
   logic       busy [NI];
   logic       done [NI];
   logic [7:0] mem_addr [NI];
   logic [7:0] mem_rdata [NI];
   logic [7:0] out_data [NI];
   logic [7:0] mem [256];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rdy_mode [NI];
   int issued [NI];
   int xfer_cnt [NI];
   int done_cnt [NI];
   int first_cyc [NI];
   logic [8:0] exp_q [NI][$];

   for (genvar g = 0; g < NI; g++) begin : inst
      image_read_ctrl #(.NUM_BYTES(nb(g)), .ADDR_W(8), .DATA_W(8)) dut (
         .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
         .mem_rd_en(mem_rd_en[g]), .mem_addr(mem_addr[g]), .mem_rdata(mem_rdata[g]),
         .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_data(out_data[g]),
         .out_last(out_last[g]), .busy(busy[g]), .done(done[g])
      );
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous memory: data appears the cycle after the read strobe.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++)
         if (mem_rd_en[g]) mem_rdata[g] <= mem[mem_addr[g]];
   end

   task automatic chk(input string name, input int g, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s[%0d] actual=%0h required=%0h", name, g, act, exp);
      end
   endtask

   // out_ready patterns: 0 = always 1, 1 = 1,0,0,1,0,1 repeating, 2 = random, 3 = held 0
   initial begin
      int ph [NI];
      logic [5:0] pat;
      pat = 6'b101001;
      for (int g = 0; g < NI; g++) begin out_ready[g] = 1'b0; ph[g] = 0; end
      forever begin
         @(posedge clk);
         #2;
         for (int g = 0; g < NI; g++) begin
            case (rdy_mode[g])
               0: out_ready[g] = 1'b1;
               1: begin out_ready[g] = pat[ph[g] % 6]; ph[g]++; end
               2: out_ready[g] = 1'($urandom_range(0, 1));
               default: out_ready[g] = 1'b0;
            endcase
         end
      end
   end

   initial begin
      logic [7:0] pd [NI];
      logic       pl [NI];
      bit         stall [NI];
      bit         last_x [NI];
      bit         busy_chk [NI];
      int         prev_x [NI];
      logic [8:0] e;
      int         outst;
      for (int g = 0; g < NI; g++) begin
         stall[g] = 0; last_x[g] = 0; busy_chk[g] = 0; prev_x[g] = 0;
         issued[g] = 0; xfer_cnt[g] = 0; done_cnt[g] = 0; first_cyc[g] = 0;
      end
      forever begin
         @(negedge clk);
         for (int g = 0; g < NI; g++) begin
            if (!rst_n) begin
               stall[g] = 0; last_x[g] = 0; busy_chk[g] = 0; issued[g] = 0; xfer_cnt[g] = 0;
               continue;
            end
            if (busy_chk[g]) begin chk("busy_low_after_done", g, busy[g], 0); busy_chk[g] = 0; end
            if (last_x[g]) begin chk("done_after_last", g, done[g], 1); last_x[g] = 0; end
            else chk("done_only_after_last", g, done[g], 0);
            if (done[g]) begin done_cnt[g]++; busy_chk[g] = 1; end
            if (stall[g]) begin
               chk("stall_valid", g, out_valid[g], 1);
               chk("stall_data", g, out_data[g], pd[g]);
               chk("stall_last", g, out_last[g], pl[g]);
            end
            if (mem_rd_en[g]) begin
               outst = issued[g] - xfer_cnt[g] - ((out_valid[g] && out_ready[g]) ? 1 : 0);
               chk("rd_addr", g, mem_addr[g], issued[g]);
               chk("rd_in_range", g, issued[g] < nb(g), 1);
               chk("rd_credit", g, outst <= 1, 1);
               issued[g]++;
            end
            if (out_valid[g] && out_ready[g]) begin
               if (exp_q[g].size() == 0) begin
                  checks++; failures++;
                  $display("FAIL extra_byte[%0d] actual=%0h required=none", g, out_data[g]);
               end else begin
                  e = exp_q[g].pop_front();
                  chk("byte_data", g, out_data[g], e[7:0]);
                  chk("byte_last", g, out_last[g], e[8]);
                  if (e[8]) last_x[g] = 1;
               end
               if (xfer_cnt[g] == 0) first_cyc[g] = cyc;
               else if (rdy_mode[g] == 0) chk("throughput", g, cyc, prev_x[g] + 1);
               prev_x[g] = cyc;
               xfer_cnt[g]++;
            end
            stall[g] = out_valid[g] && !out_ready[g] && !abort[g];
            pd[g] = out_data[g];
            pl[g] = out_last[g];
            if (!busy[g]) begin issued[g] = 0; xfer_cnt[g] = 0; end
         end
      end
   end

   task automatic load_exp(input int g);
      for (int a = 0; a < nb(g); a++) exp_q[g].push_back({(a == nb(g) - 1), mem[a]});
   endtask

   task automatic run_xfer(input int g, input int mode, input bit poke);
      int s, t, d0;
      rdy_mode[g] = mode;
      d0 = done_cnt[g];
      load_exp(g);
      start[g] = 1'b1;
      @(posedge clk); #1;
      s = cyc;
      start[g] = 1'b0;
      if (poke) begin
         repeat (3) @(posedge clk);
         #1 start[g] = 1'b1;
         @(posedge clk);
         #1 start[g] = 1'b0;
      end
      t = 0;
      while (done_cnt[g] == d0 && t < 3000) begin @(posedge clk); #1; t++; end
      chk("done_seen", g, done_cnt[g] - d0, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", g, done_cnt[g] - d0, 1);
      chk("idle_after_done", g, busy[g], 0);
      chk("bytes_left", g, exp_q[g].size(), 0);
      if (mode == 0) chk("first_latency", g, first_cyc[g] - s, 2);
   endtask

   initial begin
      int t, d0;
      for (int g = 0; g < NI; g++) begin start[g] = 1'b0; abort[g] = 1'b0; rdy_mode[g] = 0; end
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      for (int a = 0; a < 4; a++) mem[a] = 8'(8'h10 + a);
      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) begin
         chk("rst_rd_en", g, mem_rd_en[g], 0);
         chk("rst_addr", g, mem_addr[g], 0);
         chk("rst_valid", g, out_valid[g], 0);
         chk("rst_data", g, out_data[g], 0);
         chk("rst_last", g, out_last[g], 0);
         chk("rst_busy", g, busy[g], 0);
         chk("rst_done", g, done[g], 0);
      end
      rst_n = 1'b1;

      run_xfer(0, 0, 1'b0);
      run_xfer(0, 1, 1'b1);
      run_xfer(1, 0, 1'b0);
      run_xfer(1, 2, 1'b0);

      // start together with abort while idle must not launch a transfer
      start[0] = 1'b1; abort[0] = 1'b1;
      @(posedge clk); #1;
      start[0] = 1'b0; abort[0] = 1'b0;
      chk("start_abort_busy", 0, busy[0], 0);
      chk("start_abort_rd", 0, mem_rd_en[0], 0);
      @(posedge clk); #1;
      chk("start_abort_busy2", 0, busy[0], 0);

      // abort the 200-byte transfer after 50 bytes
      rdy_mode[2] = 0;
      d0 = done_cnt[2];
      load_exp(2);
      start[2] = 1'b1;
      @(posedge clk); #1 start[2] = 1'b0;
      t = 0;
      while (xfer_cnt[2] < 50 && t < 500) begin @(posedge clk); #1; t++; end
      chk("abort_reach50", 2, xfer_cnt[2] >= 50, 1);
      abort[2] = 1'b1; rdy_mode[2] = 3;
      @(posedge clk); #1;
      abort[2] = 1'b0;
      chk("abort_valid", 2, out_valid[2], 0);
      chk("abort_busy", 2, busy[2], 0);
      exp_q[2].delete();
      repeat (4) begin
         @(posedge clk); #1;
         chk("abort_no_return", 2, out_valid[2], 0);
      end
      chk("abort_no_done", 2, done_cnt[2] - d0, 0);
      run_xfer(2, 2, 1'b0);

      // asynchronous reset in the middle of draining
      rdy_mode[0] = 1;
      load_exp(0);
      start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0;
      t = 0;
      while (!(issued[0] == 4 && busy[0]) && t < 100) begin @(posedge clk); #1; t++; end
      chk("drain_reached", 0, issued[0], 4);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_rd_en", 0, mem_rd_en[0], 0);
      chk("arst_addr", 0, mem_addr[0], 0);
      chk("arst_valid", 0, out_valid[0], 0);
      chk("arst_data", 0, out_data[0], 0);
      chk("arst_last", 0, out_last[0], 0);
      chk("arst_busy", 0, busy[0], 0);
      chk("arst_done", 0, done[0], 0);
      exp_q[0].delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("post_rst_valid", 0, out_valid[0], 0);
         chk("post_rst_busy", 0, busy[0], 0);
      end
      run_xfer(0, 2, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
